// File: rtl/sim_trap_monitor.sv
// sim_trap_monitor: watches the retire ports of a simulated core. It halts on
// ebreak or after a long run with nothing retired, and reports the exit status
// along with cycle and retired-instruction counts.
// Optional feature: define SIM_TRAP_FINISH_EN to print the exit status and call
// $finish on entering DONE. Without it the design contains no system tasks.
module sim_trap_monitor #(
    parameter int NR_CH        = 1,
    parameter int XLEN         = 64,
    parameter int IDLE_LIMIT   = 1024,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NR_CH-1:0]      retire_valid,
    input  logic [32*NR_CH-1:0]   retire_inst,
    input  logic [XLEN*NR_CH-1:0] retire_pc,
    input  logic [XLEN-1:0]       a0,
    output logic                  halt,
    output logic                  good_trap,
    output logic                  timeout,
    output logic [XLEN-1:0]       exit_code,
    output logic [XLEN-1:0]       halt_pc,
    output logic [63:0]           cycle_cnt,
    output logic [63:0]           instret_cnt
);

    localparam logic [31:0] EBREAK = 32'h00100073;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [31:0]     drain_cnt;
    logic [31:0]     idle_cnt;
    logic            good_pend;
    logic            to_pend;

    logic            ebreak_hit;
    logic            timeout_hit;
    logic            trigger;
    logic            trig_good;
    logic [XLEN-1:0] trap_pc;
    logic [3:0]      trap_add;
    logic [3:0]      all_add;

    // Find the lowest-index ebreak and the retire counts for this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        ebreak_hit = 1'b0;
        trap_pc    = '0;
        trap_add   = '0;
        all_add    = '0;
        for (int i = 0; i < NR_CH; i++) begin
            if (retire_valid[i]) begin
                all_add = all_add + 4'd1;
                // Channels up to and including the trapping one still retire.
                if (!ebreak_hit) begin
                    trap_add = trap_add + 4'd1;
                end
                if (!ebreak_hit && retire_inst[32*i +: 32] == EBREAK) begin
                    ebreak_hit = 1'b1;
                    trap_pc    = retire_pc[XLEN*i +: XLEN];
                end
            end
        end
        timeout_hit = (IDLE_LIMIT != 0) && (idle_cnt == 32'(IDLE_LIMIT));
        trigger     = ebreak_hit || timeout_hit;
        trig_good   = ebreak_hit && (a0 == '0);
    end

    // Trap FSM, counters and latched exit status.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state       <= RUN;
            drain_cnt   <= '0;
            idle_cnt    <= '0;
            good_pend   <= 1'b0;
            to_pend     <= 1'b0;
            halt        <= 1'b0;
            good_trap   <= 1'b0;
            timeout     <= 1'b0;
            exit_code   <= '0;
            halt_pc     <= '0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + 64'd1;
                    end
                    if (retire_valid != '0) begin
                        idle_cnt <= '0;
                    end else if (IDLE_LIMIT != 0) begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                    if (trigger) begin
                        // ebreak wins over a simultaneous timeout.
                        instret_cnt <= instret_cnt + 64'(ebreak_hit ? trap_add : all_add);
                        halt_pc     <= ebreak_hit ? trap_pc : '0;
                        exit_code   <= ebreak_hit ? a0 : '1;
                        good_pend   <= trig_good;
                        to_pend     <= !ebreak_hit;
                        if (DRAIN_CYCLES == 0) begin
                            state     <= DONE;
                            halt      <= 1'b1;
                            good_trap <= trig_good;
                            timeout   <= !ebreak_hit;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end else begin
                        instret_cnt <= instret_cnt + 64'(all_add);
                    end
                end
                DRAIN: begin
                    // Retire inputs are ignored; just count down the drain window.
                    if (drain_cnt == 32'(DRAIN_CYCLES - 1)) begin
                        state     <= DONE;
                        halt      <= 1'b1;
                        good_trap <= good_pend;
                        timeout   <= to_pend;
                    end else begin
                        drain_cnt <= drain_cnt + 32'd1;
                    end
                end
                DONE: begin
                    // Terminal until reset.
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef SIM_TRAP_FINISH_EN
    // Report the exit status on the first edge in DONE, then end simulation.
    always @(posedge clock) begin
        if (!reset && halt) begin
            $display("sim_trap_monitor: %s halt_pc=0x%0h exit_code=0x%0h cycles=%0d instret=%0d",
                     timeout ? "TIMEOUT" : (good_trap ? "GOOD" : "BAD"),
                     halt_pc, exit_code, cycle_cnt, instret_cnt);
            $finish;
        end
    end
`else
`endif

endmodule

// File: tb/tb_sim_trap_monitor.sv
// Directed bench for sim_trap_monitor: a 4-channel instance with a 16-cycle
// idle limit and 2-cycle drain, plus a 1-channel instance with no drain and
// the timeout disabled.
module tb_sim_trap_monitor;

    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   valid;
    logic [127:0] inst;
    logic [255:0] pc;
    logic [63:0]  a0;
    logic         h0, g0, t0;
    logic [63:0]  ec0, hp0, cc0, ic0;

    logic         valid1;
    logic [31:0]  inst1;
    logic [63:0]  pc1;
    logic         h1, g1, t1;
    logic [63:0]  ec1, hp1, cc1, ic1;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    sim_trap_monitor #(.NR_CH(4), .XLEN(64), .IDLE_LIMIT(16), .DRAIN_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .retire_valid(valid), .retire_inst(inst),
        .retire_pc(pc), .a0(a0), .halt(h0), .good_trap(g0), .timeout(t0),
        .exit_code(ec0), .halt_pc(hp0), .cycle_cnt(cc0), .instret_cnt(ic0)
    );

    sim_trap_monitor #(.NR_CH(1), .XLEN(64), .IDLE_LIMIT(0), .DRAIN_CYCLES(0)) dut1 (
        .clock(clock), .reset(reset), .retire_valid(valid1), .retire_inst(inst1),
        .retire_pc(pc1), .a0(a0), .halt(h1), .good_trap(g1), .timeout(t1),
        .exit_code(ec1), .halt_pc(hp1), .cycle_cnt(cc1), .instret_cnt(ic1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        valid  = '0;
        inst   = {4{NOP}};
        pc     = '0;
        a0     = '0;
        valid1 = 1'b0;
        inst1  = NOP;
        pc1    = '0;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] w, input logic [63:0] p);
        valid[ch]         = 1'b1;
        inst[32*ch +: 32] = w;
        pc[64*ch +: 64]   = p;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({h0, g0, t0} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {h0, g0, t0}); end
        checks++; if (ec0 !== 64'd0 || hp0 !== 64'd0) begin failures++; $display("FAIL reset_latch got ec=%0h pc=%0h exp=0", ec0, hp0); end
        checks++; if (cc0 !== 64'd0 || ic0 !== 64'd0) begin failures++; $display("FAIL reset_cnt got cc=%0d ic=%0d exp=0", cc0, ic0); end
        checks++; if ({h1, g1, t1} !== 3'b000 || cc1 !== 64'd0) begin failures++; $display("FAIL reset_dut1 got=%b cc=%0d exp=000/0", {h1, g1, t1}, cc1); end
    endtask

    task automatic test_single_channel();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            clear_inputs();
            set_ch(0, NOP, 64'h8000_0000 + 64'(4 * i));
            tick();
        end
        clear_inputs();
        set_ch(0, EBREAK, 64'h8000_0028);
        a0 = 64'd0;
        tick();
        checks++; if (h0 !== 1'b0) begin failures++; $display("FAIL single_halt_n1 got=%b exp=0", h0); end
        // Retires during DRAIN must be ignored.
        clear_inputs();
        set_ch(0, EBREAK, 64'h1234);
        set_ch(1, NOP, 64'h1238);
        a0 = 64'd9;
        tick();
        checks++; if (h0 !== 1'b0) begin failures++; $display("FAIL single_halt_n2 got=%b exp=0", h0); end
        clear_inputs();
        tick();
        checks++; if (h0 !== 1'b1 || g0 !== 1'b1 || t0 !== 1'b0) begin failures++; $display("FAIL single_flags got=%b%b%b exp=110", h0, g0, t0); end
        checks++; if (ic0 !== 64'd11) begin failures++; $display("FAIL single_instret got=%0d exp=11", ic0); end
        checks++; if (cc0 !== 64'd11) begin failures++; $display("FAIL single_cycle got=%0d exp=11", cc0); end
        checks++; if (hp0 !== 64'h8000_0028 || ec0 !== 64'd0) begin failures++; $display("FAIL single_latch got pc=%0h ec=%0h exp=80000028/0", hp0, ec0); end
        tick();
        checks++; if (h0 !== 1'b1 || cc0 !== 64'd11) begin failures++; $display("FAIL single_done_hold got h=%b cc=%0d exp=1/11", h0, cc0); end
    endtask

    task automatic test_dual_channel();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            for (int c = 0; c < 4; c++) set_ch(c, NOP, 64'(16 * i + 4 * c));
            tick();
        end
        clear_inputs();
        set_ch(0, EBREAK, 64'h100);
        set_ch(1, NOP, 64'h104);
        a0 = 64'd5;
        tick();
        clear_inputs();
        tick();
        tick();
        checks++; if (h0 !== 1'b1 || g0 !== 1'b0 || t0 !== 1'b0) begin failures++; $display("FAIL dual_flags got=%b%b%b exp=100", h0, g0, t0); end
        checks++; if (ec0 !== 64'd5) begin failures++; $display("FAIL dual_exit got=%0d exp=5", ec0); end
        checks++; if (ic0 !== 64'd13) begin failures++; $display("FAIL dual_instret got=%0d exp=13", ic0); end
        checks++; if (hp0 !== 64'h100 || cc0 !== 64'd4) begin failures++; $display("FAIL dual_pc_cycle got pc=%0h cc=%0d exp=100/4", hp0, cc0); end
    endtask

    task automatic test_multi_ebreak();
        do_reset();
        set_ch(0, NOP, 64'h2000);
        set_ch(1, EBREAK, 64'h2004);
        set_ch(2, NOP, 64'h2008);
        set_ch(3, EBREAK, 64'h200C);
        a0 = 64'd0;
        tick();
        clear_inputs();
        tick();
        tick();
        checks++; if (hp0 !== 64'h2004) begin failures++; $display("FAIL multi_pc got=%0h exp=2004", hp0); end
        checks++; if (ic0 !== 64'd2) begin failures++; $display("FAIL multi_instret got=%0d exp=2", ic0); end
        checks++; if (h0 !== 1'b1 || g0 !== 1'b1 || cc0 !== 64'd1) begin failures++; $display("FAIL multi_flags got h=%b g=%b cc=%0d exp=1/1/1", h0, g0, cc0); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 18; i++) tick();
        checks++; if (h0 !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b exp=0", h0); end
        tick();
        checks++; if (h0 !== 1'b1 || t0 !== 1'b1 || g0 !== 1'b0) begin failures++; $display("FAIL timeout_flags got=%b%b%b exp=101", h0, g0, t0); end
        checks++; if (ec0 !== '1 || hp0 !== 64'd0) begin failures++; $display("FAIL timeout_latch got ec=%0h pc=%0h exp=ffffffffffffffff/0", ec0, hp0); end
        checks++; if (cc0 !== 64'd17 || ic0 !== 64'd0) begin failures++; $display("FAIL timeout_cnt got cc=%0d ic=%0d exp=17/0", cc0, ic0); end
        checks++; if (h1 !== 1'b0 || cc1 !== 64'd19) begin failures++; $display("FAIL timeout_disabled got h=%b cc=%0d exp=0/19", h1, cc1); end
    endtask

    task automatic test_idle_collision();
        do_reset();
        for (int i = 0; i < 16; i++) tick();
        set_ch(0, EBREAK, 64'h300);
        a0 = 64'd0;
        tick();
        clear_inputs();
        tick();
        tick();
        checks++; if (h0 !== 1'b1 || t0 !== 1'b0 || g0 !== 1'b1) begin failures++; $display("FAIL collide_flags got=%b%b%b exp=110", h0, g0, t0); end
        checks++; if (hp0 !== 64'h300 || ic0 !== 64'd1 || cc0 !== 64'd17) begin failures++; $display("FAIL collide_latch got pc=%0h ic=%0d cc=%0d exp=300/1/17", hp0, ic0, cc0); end
    endtask

    task automatic test_idle_rearm();
        do_reset();
        for (int i = 0; i < 15; i++) tick();
        set_ch(0, NOP, 64'h40);
        tick();
        clear_inputs();
        for (int i = 0; i < 15; i++) tick();
        checks++; if (h0 !== 1'b0 || ic0 !== 64'd1) begin failures++; $display("FAIL rearm got h=%b ic=%0d exp=0/1", h0, ic0); end
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        set_ch(0, NOP, 64'h10);
        tick();
        tick();
        clear_inputs();
        set_ch(0, EBREAK, 64'h18);
        tick();
        clear_inputs();
        reset = 1'b1;
        tick();
        checks++; if (h0 !== 1'b0 || cc0 !== 64'd0 || ic0 !== 64'd0 || hp0 !== 64'd0) begin failures++; $display("FAIL drain_reset got h=%b cc=%0d ic=%0d pc=%0h exp=0/0/0/0", h0, cc0, ic0, hp0); end
        reset = 1'b0;
        set_ch(0, NOP, 64'h3FC);
        tick();
        clear_inputs();
        set_ch(0, EBREAK, 64'h400);
        a0 = 64'd3;
        tick();
        clear_inputs();
        tick();
        checks++; if (h0 !== 1'b0) begin failures++; $display("FAIL drain_rerun_early got=%b exp=0", h0); end
        tick();
        checks++; if (h0 !== 1'b1 || g0 !== 1'b0 || ec0 !== 64'd3) begin failures++; $display("FAIL drain_rerun got h=%b g=%b ec=%0d exp=1/0/3", h0, g0, ec0); end
        checks++; if (ic0 !== 64'd2 || cc0 !== 64'd2 || hp0 !== 64'h400) begin failures++; $display("FAIL drain_rerun_cnt got ic=%0d cc=%0d pc=%0h exp=2/2/400", ic0, cc0, hp0); end
    endtask

    task automatic test_no_drain();
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        checks++; if (h1 !== 1'b0) begin failures++; $display("FAIL nodrain_idle got=%b exp=0", h1); end
        valid1 = 1'b1;
        inst1  = EBREAK;
        pc1    = 64'h500;
        a0     = 64'd0;
        tick();
        clear_inputs();
        checks++; if (h1 !== 1'b1 || g1 !== 1'b1 || t1 !== 1'b0) begin failures++; $display("FAIL nodrain_flags got=%b%b%b exp=110", h1, g1, t1); end
        checks++; if (cc1 !== 64'd21 || ic1 !== 64'd1 || hp1 !== 64'h500 || ec1 !== 64'd0) begin failures++; $display("FAIL nodrain_latch got cc=%0d ic=%0d pc=%0h ec=%0h exp=21/1/500/0", cc1, ic1, hp1, ec1); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_channel();
        test_dual_channel();
        test_multi_ebreak();
        test_timeout();
        test_idle_collision();
        test_idle_rearm();
        test_reset_in_drain();
        test_no_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
